// File: rtl/div.sv
// div: sequential restoring divider, 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, MSB first. Optional macro: DIV_ZERO_CHECK_EN.
module div #(
    parameter int W = 8
) (
    input  logic           ck,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] Q,
    output logic [W-1:0]   R,
    output logic           fin,
    output logic           busy,
    output logic           err
);

    localparam int CW = $clog2(2 * W);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    // Dividend shifts out of the MSB while quotient bits shift in at the LSB.
    logic [2*W-1:0] aq_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   r_q;
    logic [2*W-1:0] q_q;
    logic [W-1:0]   rem_q;
    logic           fin_q;
    logic           busy_q;

    logic [W:0]     p_d;
    logic           qbit_d;
    logic [W-1:0]   r_d;
    logic [2*W-1:0] aq_d;
    logic           last_d;

    // One restoring step: W+1-bit trial subtract of the divisor.
    always_comb begin
        p_d    = {r_q, aq_q[2*W-1]};
        qbit_d = (p_d >= {1'b0, b_q});
        r_d    = qbit_d ? W'(p_d - {1'b0, b_q}) : p_d[W-1:0];
        aq_d   = {aq_q[2*W-2:0], qbit_d};
        last_d = (cnt_q == CW'(2 * W - 1));
    end

`ifdef DIV_ZERO_CHECK_EN
    logic err_q;
`endif

    // Control FSM and datapath; start has priority over finishing.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            aq_q    <= '0;
            b_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            fin_q <= 1'b0;
            if (start) begin
                state_q <= RUN;
                aq_q    <= A;
                b_q     <= B;
                r_q     <= '0;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                err_q   <= 1'b0;
`endif
            end else if (state_q == RUN) begin
`ifdef DIV_ZERO_CHECK_EN
                if (b_q == '0) begin
                    q_q     <= '1;
                    rem_q   <= aq_q[W-1:0];
                    err_q   <= 1'b1;
                    fin_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end else
`endif
                begin
                    aq_q  <= aq_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_d) begin
                        q_q     <= aq_d;
                        rem_q   <= r_d;
                        fin_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            end
        end
    end

    assign Q    = q_q;
    assign R    = rem_q;
    assign fin  = fin_q;
    assign busy = busy_q;
`ifdef DIV_ZERO_CHECK_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule
